instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Inverse of the opcode/immediate-format decode path in the multi-cycle RISC-V core. It accepts decoded instruction fields over a valid/ready handshake and assembles them into 32-bit RV32I machine words for the supported subset: lw, sw, R-type, beq, I-type ALU and jal. It writes each encoded word sequentially into the instruction/data memory write port, so directed test programs can be preloaded without a hex file.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- DEPTH, 64, maximum words per load session (power of two, 2..1024)

Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin session; one-cycle pulse
- last  in  1  qualifies the final field set of a session; sampled with in_valid
- in_valid  in  1  field set valid
- in_ready  out  1  block can accept a field set this cycle
- fmt  in  3  0=lw, 1=sw, 2=R, 3=beq, 4=I-ALU, 5=jal, 6..7=illegal
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  used for R and I-ALU only
- funct7b5  in  1  R-type funct7 bit 5 (add/sub)
- imm  in  21  signed immediate in bits [20:0]
- mem_we  out  1  memory write strobe
- mem_addr  out  32  byte address
- mem_wdata  out  32  encoded instruction
- count  out  $clog2(DEPTH)+1  words written this session
- busy  out  1  session active
- done  out  1  one-cycle pulse after the final write
- err  out  1  sticky error flag; cleared by start

## Operation
- States are IDLE, LOAD and FLUSH.
  - IDLE to LOAD on start.
  - LOAD to FLUSH on an accepted beat with last=1, or when the pointer reaches DEPTH.
  - FLUSH to IDLE after the pending write retires. done pulses on that same cycle.
- start in LOAD or FLUSH restarts the session: pointer=0, count=0, err=0, and any pending write is dropped.
- in_ready = (state==LOAD) && (ptr<DEPTH).
- Accept occurs on in_valid && in_ready. The pointer increments only for legal beats.
- Encoding, with funct3 forced where fixed:
  - lw: {imm[11:0],rs1,3'b010,rd,7'b0000011}
  - sw: {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}
  - R: {1'b0,funct7b5,5'b0,rs2,rs1,funct3,rd,7'b0110011}
  - beq: {imm[12],imm[10:5],rs2,rs1,3'b000,imm[4:1],imm[11],7'b1100011}
  - I-ALU: {imm[11:0],rs1,funct3,rd,7'b0010011}
  - jal: {imm[20],imm[10:1],imm[11],imm[19:12],rd,7'b1101111}
- Illegal beat: fmt 6..7, or beq/jal with imm[0]=1. The beat is accepted and dropped: no write, no pointer advance, err set. last on an illegal beat still ends the session.
- Immediate range is not checked. Bits above each format's field are discarded.
- mem_addr = BASE_ADDR + 4*ptr at the time of accept.
- At ptr==DEPTH, in_ready is low and the block moves to FLUSH. Further beats stall and are never written. No wrap-around occurs.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0
  - count=0, busy=0, done=0, err=0
- Write latency is 1 cycle: a beat accepted at edge N drives mem_we=1 with registered mem_addr and mem_wdata during cycle N+1.
- count increments on the edge ending that write cycle.
- Throughput is 1 beat per cycle. Back-to-back accepts produce back-to-back writes at consecutive addresses.
- busy=1 in LOAD and FLUSH.
- done asserts in the cycle after the final mem_we, or one cycle after FLUSH entry if no write is pending.
- reset mid-session aborts immediately. mem_we drops asynchronously and no partial word is committed.
- If start coincides with in_valid in IDLE, no beat is accepted; in_ready rises the next cycle.

## Test plan
- lw x5,8(x1) then add x3,x1,x2 with last=1 -> writes 0x0080A283 @0x0 and 0x002081B3 @0x4 on consecutive cycles, done pulses, count=2.
- sw x2,4(x3) -> 0x0021A223; beq x1,x2,8 -> 0x00208463; jal x1,8 -> 0x008000EF.
- fmt=7 between two legal beats -> err=1, addresses stay contiguous (0x0, 0x4), count=2.
- DEPTH=4, six valid beats with no last -> exactly 4 writes @0x0..0xC, in_ready low after the 4th accept, done asserts, remaining beats stall.
- reset asserted one cycle after an accept -> mem_we=0 immediately, all outputs at reset values, no write observed.
- start pulsed during LOAD with err=1 -> count=0, err=0, next legal beat writes @BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - field-set input and memory write bus for the encoder loader
interface instr_encoder_loader_if #(
    parameter int DEPTH = 64
);
    logic                     start;
    logic                     last;
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               fmt;
    logic [4:0]               rd;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic [20:0]              imm;
    logic                     mem_we;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [$clog2(DEPTH):0]   count;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, last, in_valid, fmt, rd, rs1, rs2, funct3, funct7b5, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );

    modport slave (
        input  start, last, in_valid, fmt, rd, rs1, rs2, funct3, funct7b5, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I field sets and writes them sequentially to memory
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_encoder_loader_if.slave  bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t         state;
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  count_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           in_ready_c;
    logic           accept;
    logic           legal;
    logic [31:0]    enc;

    // A start pulse always wins over a beat presented in the same cycle.
    assign in_ready_c = (state == LOAD) && (ptr < DEPTH_C);
    assign accept     = bus.in_valid && in_ready_c && !bus.start;

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // Legality check and RV32I word assembly for the current field set.
    always_comb begin
        legal = 1'b1;
        enc   = 32'h0;
        case (bus.fmt)
            3'd0: enc = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
            3'd1: enc = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
            3'd2: enc = {1'b0, bus.funct7b5, 5'b00000, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
            3'd3: begin
                enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                         bus.imm[4:1], bus.imm[11], 7'b1100011};
                legal = !bus.imm[0];
            end
            3'd4: enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
            3'd5: begin
                enc   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, 7'b1101111};
                legal = !bus.imm[0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Session FSM with registered write port, counters and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;
            if (mem_we_q) begin
                count_q <= count_q + 1'b1;
            end
            if (bus.start) begin
                state   <= LOAD;
                busy_q  <= 1'b1;
                ptr     <= '0;
                count_q <= '0;
                err_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (accept) begin
                            if (legal) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= BASE_ADDR + (32'(ptr) << 2);
                                mem_wdata_q <= enc;
                                ptr         <= ptr + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            if (bus.last || (legal && (ptr + 1'b1 == DEPTH_C))) begin
                                state <= FLUSH;
                            end
                        end
                    end
                    FLUSH: begin
                        // The only possible pending write retires during this cycle.
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   nb_writes = 0;
    int   snap;
    logic [31:0] d_addrs[$];

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.DEPTH(64)) b();
    instr_encoder_loader_if #(.DEPTH(4))  d();

    instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (d)
    );

    // Record writes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (b.mem_we === 1'b1) nb_writes <= nb_writes + 1;
        if (d.mem_we === 1'b1) d_addrs.push_back(d.mem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
    endtask

    task automatic beat(input logic [2:0] f, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input logic [2:0] f3, input logic f7,
                        input logic [20:0] im, input logic lst);
        b.fmt = f; b.rd = rd_i; b.rs1 = rs1_i; b.rs2 = rs2_i;
        b.funct3 = f3; b.funct7b5 = f7; b.imm = im; b.last = lst;
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        b.last = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] w);
        chk({tag, "_we"}, 32'(b.mem_we), 32'd1);
        chk({tag, "_addr"}, b.mem_addr, a);
        chk({tag, "_data"}, b.mem_wdata, w);
    endtask

    initial begin
        b.start = 0; b.last = 0; b.in_valid = 0; b.fmt = 0; b.rd = 0; b.rs1 = 0;
        b.rs2 = 0; b.funct3 = 0; b.funct7b5 = 0; b.imm = 0;
        d.start = 0; d.last = 0; d.in_valid = 0; d.fmt = 0; d.rd = 0; d.rs1 = 0;
        d.rs2 = 0; d.funct3 = 0; d.funct7b5 = 0; d.imm = 0;
        #2;
        chk("rst_in_ready", 32'(b.in_ready), 0);
        chk("rst_mem_we", 32'(b.mem_we), 0);
        chk("rst_mem_addr", b.mem_addr, 32'h0);
        chk("rst_mem_wdata", b.mem_wdata, 32'h0);
        chk("rst_count", 32'(b.count), 0);
        chk("rst_busy", 32'(b.busy), 0);
        chk("rst_done", 32'(b.done), 0);
        chk("rst_err", 32'(b.err), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // lw then add with last
        pulse_start();
        chk("s1_busy", 32'(b.busy), 1);
        chk("s1_in_ready", 32'(b.in_ready), 1);
        beat(3'd0, 5'd5, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b0);
        expect_write("lw", 32'h0, 32'h0080A283);
        chk("s1_count_mid", 32'(b.count), 0);
        beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b1);
        expect_write("add", 32'h4, 32'h002081B3);
        chk("s1_ready_flush", 32'(b.in_ready), 0);
        chk("s1_count_1", 32'(b.count), 1);
        tick();
        chk("s1_done", 32'(b.done), 1);
        chk("s1_count", 32'(b.count), 2);
        chk("s1_busy_end", 32'(b.busy), 0);
        chk("s1_we_end", 32'(b.mem_we), 0);
        tick();
        chk("s1_done_pulse", 32'(b.done), 0);

        // format coverage including negative immediates
        pulse_start();
        beat(3'd1, 5'd0, 5'd3, 5'd2, 3'd0, 1'b0, 21'd4, 1'b0);
        expect_write("sw", 32'h0, 32'h0021A223);
        beat(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd8, 1'b0);
        expect_write("beq", 32'h4, 32'h00208463);
        beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0, 1'b0);
        expect_write("sub", 32'h8, 32'h402081B3);
        beat(3'd4, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFF, 1'b0);
        expect_write("addi_m1", 32'hC, 32'hFFF00313);
        beat(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFC, 1'b0);
        expect_write("beq_m4", 32'h10, 32'hFE000EE3);
        beat(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFC, 1'b0);
        expect_write("jal_m4", 32'h14, 32'hFFDFF06F);
        beat(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1);
        expect_write("jal", 32'h18, 32'h008000EF);
        tick();
        chk("s2_done", 32'(b.done), 1);
        chk("s2_count", 32'(b.count), 7);
        chk("s2_err", 32'(b.err), 0);

        // illegal beats between legal ones
        pulse_start();
        beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0);
        expect_write("s3_add", 32'h0, 32'h002081B3);
        beat(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0, 1'b0);
        chk("s3_fmt7_we", 32'(b.mem_we), 0);
        chk("s3_fmt7_err", 32'(b.err), 1);
        beat(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd9, 1'b0);
        chk("s3_oddbeq_we", 32'(b.mem_we), 0);
        beat(3'd0, 5'd5, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1);
        expect_write("s3_lw", 32'h4, 32'h0080A283);
        tick();
        chk("s3_done", 32'(b.done), 1);
        chk("s3_count", 32'(b.count), 2);
        chk("s3_err", 32'(b.err), 1);

        // restart during LOAD clears err and count
        pulse_start();
        beat(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0, 1'b0);
        chk("s4_err", 32'(b.err), 1);
        beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0);
        expect_write("s4_add", 32'h0, 32'h002081B3);
        pulse_start();
        chk("s4_rs_count", 32'(b.count), 0);
        chk("s4_rs_err", 32'(b.err), 0);
        chk("s4_rs_we", 32'(b.mem_we), 0);
        chk("s4_rs_busy", 32'(b.busy), 1);
        beat(3'd0, 5'd5, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1);
        expect_write("s4_lw", 32'h0, 32'h0080A283);
        tick();
        chk("s4_done", 32'(b.done), 1);
        chk("s4_count", 32'(b.count), 1);

        // reset right after an accept
        pulse_start();
        snap = nb_writes;
        beat(3'd0, 5'd5, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8, 1'b0);
        reset = 1'b1;
        #1;
        chk("s5_we", 32'(b.mem_we), 0);
        chk("s5_addr", b.mem_addr, 32'h0);
        chk("s5_wdata", b.mem_wdata, 32'h0);
        chk("s5_busy", 32'(b.busy), 0);
        chk("s5_ready", 32'(b.in_ready), 0);
        @(negedge clk);
        #1;
        chk("s5_no_write", 32'(nb_writes), 32'(snap));
        reset = 1'b0;
        tick();
        chk("s5_idle_busy", 32'(b.busy), 0);
        chk("s5_idle_count", 32'(b.count), 0);

        // DEPTH=4 overflow: six beats offered, four written
        d.start = 1'b1;
        tick();
        d.start = 1'b0;
        d.fmt = 3'd2; d.rd = 5'd3; d.rs1 = 5'd1; d.rs2 = 5'd2;
        d.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("d4_we_%0d", k), 32'(d.mem_we), 1);
            chk($sformatf("d4_addr_%0d", k), d.mem_addr, 32'(4 * k));
            chk($sformatf("d4_ready_%0d", k), 32'(d.in_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        chk("d4_wdata", d.mem_wdata, 32'h002081B3);
        tick();
        chk("d4_done", 32'(d.done), 1);
        chk("d4_count", 32'(d.count), 4);
        chk("d4_we_stall", 32'(d.mem_we), 0);
        chk("d4_ready_stall", 32'(d.in_ready), 0);
        tick();
        chk("d4_done_pulse", 32'(d.done), 0);
        chk("d4_we_stall2", 32'(d.mem_we), 0);
        d.in_valid = 1'b0;
        tick();
        chk("d4_nwrites", 32'(d_addrs.size()), 4);
        if (d_addrs.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("d4_mon_addr_%0d", k), d_addrs[k], 32'(4 * k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
